// File: rtl/noc_flit_sink_pkg.sv
// Shared flit layout, error-bit indices and sink FSM states for the NoC flit sink.
// Latency: n/a (constants, types and one combinational flit builder).
// Backpressure: n/a.
package noc_flit_sink_pkg;

    // Flit layout, MSB to LSB:
    // [31:28] H marker | [27:24] src {x,y} | [23:20] dst {x,y} | [19:12] LEN | [11:0] E marker
    localparam int NOC_DATA_WIDTH   = 32;
    localparam int NOC_ID_X_WIDTH   = 2;
    localparam int NOC_ID_Y_WIDTH   = 2;
    localparam int AXI_LEN_BIT      = 8;
    localparam int NOC_POINT_H      = 28;
    localparam int NOC_SOURCE_POINT = 24;
    localparam int NOC_DEST_POINT   = 20;
    localparam int AXI_LEN_POINT    = 12;
    localparam int NOC_POINT_E      = 0;

    localparam int MARK_H_W  = NOC_DATA_WIDTH - NOC_POINT_H;
    localparam int MARK_E_W  = AXI_LEN_POINT - NOC_POINT_E;
    localparam int PKT_LEN_W = AXI_LEN_BIT + 1;

    localparam logic [MARK_H_W-1:0] NOC_HEAD_H = 4'hA;
    localparam logic [MARK_H_W-1:0] NOC_TAIL_H = 4'h5;
    localparam logic [MARK_E_W-1:0] NOC_HEAD_E = 12'h3C5;
    localparam logic [MARK_E_W-1:0] NOC_TAIL_E = 12'hC3A;

    // Error flag bit positions in pkt_err
    localparam int ERR_W      = 5;
    localparam int ERR_DST    = 0;  // header addressed to another node
    localparam int ERR_LEN    = 1;  // payload count differs from LEN+1
    localparam int ERR_ROUTE  = 2;  // tail src/dst differ from header
    localparam int ERR_ABORT  = 3;  // packet cut short by a new header
    localparam int ERR_BADHDR = 4;  // header sideband set but markers wrong

    typedef enum logic [1:0] {
        WAIT_HEAD = 2'd0,
        PAYLOAD   = 2'd1,
        DRAIN     = 2'd2
    } sink_state_t;

    function automatic logic [NOC_DATA_WIDTH-1:0] make_flit(
        input logic [MARK_H_W-1:0]       mh,
        input logic [NOC_ID_X_WIDTH-1:0] sx,
        input logic [NOC_ID_Y_WIDTH-1:0] sy,
        input logic [NOC_ID_X_WIDTH-1:0] dx,
        input logic [NOC_ID_Y_WIDTH-1:0] dy,
        input logic [AXI_LEN_BIT-1:0]    len,
        input logic [MARK_E_W-1:0]       me
    );
        logic [NOC_DATA_WIDTH-1:0] f;
        f = '0;
        f[NOC_POINT_H +: MARK_H_W]                            = mh;
        f[NOC_SOURCE_POINT + NOC_ID_Y_WIDTH +: NOC_ID_X_WIDTH] = sx;
        f[NOC_SOURCE_POINT +: NOC_ID_Y_WIDTH]                 = sy;
        f[NOC_DEST_POINT + NOC_ID_Y_WIDTH +: NOC_ID_X_WIDTH]   = dx;
        f[NOC_DEST_POINT +: NOC_ID_Y_WIDTH]                   = dy;
        f[AXI_LEN_POINT +: AXI_LEN_BIT]                       = len;
        f[NOC_POINT_E +: MARK_E_W]                            = me;
        return f;
    endfunction

endpackage

// File: rtl/noc_flit_sink_decode.sv
// Combinational flit classifier: header/bad-header/tail hits plus src, dst and LEN fields.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports: flit + is_header/is_tail in, hit flags and fields out.
module noc_flit_decode
    import noc_flit_sink_pkg::*;
(
    input  logic [NOC_DATA_WIDTH-1:0] flit,
    input  logic                      is_header,
    input  logic                      is_tail,
    output logic                      hdr_hit,
    output logic                      bad_hdr,
    output logic                      tail_hit,
    output logic [NOC_ID_X_WIDTH-1:0] src_x,
    output logic [NOC_ID_Y_WIDTH-1:0] src_y,
    output logic [NOC_ID_X_WIDTH-1:0] dst_x,
    output logic [NOC_ID_Y_WIDTH-1:0] dst_y,
    output logic [AXI_LEN_BIT-1:0]    len
);
    logic [MARK_H_W-1:0] mark_h;
    logic [MARK_E_W-1:0] mark_e;
    logic                head_mark;

    assign mark_h    = flit[NOC_DATA_WIDTH-1:NOC_POINT_H];
    assign mark_e    = flit[AXI_LEN_POINT-1:NOC_POINT_E];
    assign head_mark = (mark_h == NOC_HEAD_H) && (mark_e == NOC_HEAD_E);

    assign hdr_hit  = is_header && head_mark;
    assign bad_hdr  = is_header && !head_mark;
    // The tail sideband is not always driven by senders, so the markers alone also close.
    assign tail_hit = is_tail || ((mark_h == NOC_TAIL_H) && (mark_e == NOC_TAIL_E));

    assign src_x = flit[NOC_SOURCE_POINT + NOC_ID_Y_WIDTH +: NOC_ID_X_WIDTH];
    assign src_y = flit[NOC_SOURCE_POINT +: NOC_ID_Y_WIDTH];
    assign dst_x = flit[NOC_DEST_POINT + NOC_ID_Y_WIDTH +: NOC_ID_X_WIDTH];
    assign dst_y = flit[NOC_DEST_POINT +: NOC_ID_Y_WIDTH];
    assign len   = flit[AXI_LEN_POINT +: AXI_LEN_BIT];

endmodule

// File: rtl/noc_flit_sink.sv
// Local-port packet receiver: decodes header/data/tail flits, counts and XOR-folds payload, flags errors.
// Latency: pkt_done/pkt_* and orphan_flit registered, one cycle after the closing/orphan flit is accepted.
// Backpressure: receive_ready is ~sink_hold registered (one-cycle lag); 1 flit/cycle sustained when not held.
module noc_flit_sink
    import noc_flit_sink_pkg::*;
#(
    parameter logic [NOC_ID_X_WIDTH-1:0] X_ID = '0,
    parameter logic [NOC_ID_Y_WIDTH-1:0] Y_ID = '0
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst_n,
    input  logic                      receive_valid,
    output logic                      receive_ready,
    input  logic [NOC_DATA_WIDTH-1:0] receive_flit,
    input  logic                      receive_is_header,
    input  logic                      receive_is_tail,
    input  logic                      sink_hold,
    output logic                      pkt_done,
    output logic [NOC_ID_X_WIDTH-1:0] pkt_src_x,
    output logic [NOC_ID_Y_WIDTH-1:0] pkt_src_y,
    output logic [PKT_LEN_W-1:0]      pkt_len,
    output logic [NOC_DATA_WIDTH-1:0] pkt_xsum,
    output logic [ERR_W-1:0]          pkt_err,
    output logic                      orphan_flit,
    output logic [15:0]               pkt_count,
    output logic [15:0]               err_count
);
    logic                      hdr_hit, bad_hdr, tail_hit;
    logic [NOC_ID_X_WIDTH-1:0] f_src_x, f_dst_x;
    logic [NOC_ID_Y_WIDTH-1:0] f_src_y, f_dst_y;
    logic [AXI_LEN_BIT-1:0]    f_len;

    noc_flit_decode u_decode (
        .flit      (receive_flit),
        .is_header (receive_is_header),
        .is_tail   (receive_is_tail),
        .hdr_hit   (hdr_hit),
        .bad_hdr   (bad_hdr),
        .tail_hit  (tail_hit),
        .src_x     (f_src_x),
        .src_y     (f_src_y),
        .dst_x     (f_dst_x),
        .dst_y     (f_dst_y),
        .len       (f_len)
    );

    // Latched header context of the packet in flight
    logic [NOC_ID_X_WIDTH-1:0] hdr_src_x, hdr_dst_x;
    logic [NOC_ID_Y_WIDTH-1:0] hdr_src_y, hdr_dst_y;
    logic [AXI_LEN_BIT-1:0]    hdr_len;
    logic [PKT_LEN_W-1:0]      cnt;
    logic [NOC_DATA_WIDTH-1:0] xsum;
    logic [ERR_W-1:0]          cur_err;

    sink_state_t      state, state_nxt;
    logic             xfer;
    logic             do_latch, latch_bad, do_accum, do_close, do_orphan;
    logic [ERR_W-1:0] close_err, latch_err;
    logic [PKT_LEN_W-1:0] exp_len;
    logic             route_bad;

    assign xfer      = receive_valid && receive_ready;
    assign exp_len   = {1'b0, hdr_len} + PKT_LEN_W'(1);
    assign route_bad = (f_src_x != hdr_src_x) || (f_src_y != hdr_src_y) ||
                       (f_dst_x != hdr_dst_x) || (f_dst_y != hdr_dst_y);

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) state <= WAIT_HEAD;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_latch  = 1'b0;
        latch_bad = 1'b0;
        do_accum  = 1'b0;
        do_close  = 1'b0;
        do_orphan = 1'b0;
        close_err = '0;
        if (xfer) begin
            case (state)
                WAIT_HEAD: begin
                    if (hdr_hit) begin
                        do_latch  = 1'b1;
                        state_nxt = PAYLOAD;
                    end else if (bad_hdr) begin
                        do_latch  = 1'b1;
                        latch_bad = 1'b1;
                        state_nxt = DRAIN;
                    end else begin
                        do_orphan = 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (hdr_hit || bad_hdr) begin
                        // A new header aborts the current packet and starts the next one
                        // in the same cycle; a malformed one sends us to drain its body.
                        do_close             = 1'b1;
                        close_err            = cur_err;
                        close_err[ERR_ABORT] = 1'b1;
                        do_latch             = 1'b1;
                        latch_bad            = bad_hdr;
                        state_nxt            = bad_hdr ? DRAIN : PAYLOAD;
                    end else if (tail_hit) begin
                        do_close             = 1'b1;
                        close_err            = cur_err;
                        close_err[ERR_LEN]   = (cnt != exp_len);
                        close_err[ERR_ROUTE] = route_bad;
                        state_nxt            = WAIT_HEAD;
                    end else begin
                        do_accum = 1'b1;
                    end
                end
                DRAIN: begin
                    if (tail_hit) begin
                        do_close  = 1'b1;
                        close_err = cur_err;
                        state_nxt = WAIT_HEAD;
                    end
                end
                default: state_nxt = WAIT_HEAD;
            endcase
        end
    end

    always_comb begin
        latch_err = '0;
        if (latch_bad) latch_err[ERR_BADHDR] = 1'b1;
        else           latch_err[ERR_DST]    = (f_dst_x != X_ID) || (f_dst_y != Y_ID);
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            receive_ready <= 1'b0;
            hdr_src_x     <= '0;
            hdr_src_y     <= '0;
            hdr_dst_x     <= '0;
            hdr_dst_y     <= '0;
            hdr_len       <= '0;
            cnt           <= '0;
            xsum          <= '0;
            cur_err       <= '0;
            pkt_done      <= 1'b0;
            orphan_flit   <= 1'b0;
            pkt_src_x     <= '0;
            pkt_src_y     <= '0;
            pkt_len       <= '0;
            pkt_xsum      <= '0;
            pkt_err       <= '0;
            pkt_count     <= '0;
            err_count     <= '0;
        end else begin
            receive_ready <= ~sink_hold;
            pkt_done      <= do_close;
            orphan_flit   <= do_orphan;

            if (do_latch) begin
                hdr_src_x <= f_src_x;
                hdr_src_y <= f_src_y;
                hdr_dst_x <= f_dst_x;
                hdr_dst_y <= f_dst_y;
                hdr_len   <= f_len;
                cnt       <= '0;
                xsum      <= '0;
                cur_err   <= latch_err;
            end else if (do_accum) begin
                if (cnt != '1) cnt <= cnt + PKT_LEN_W'(1);
                xsum <= xsum ^ receive_flit;
            end

            // Outputs take the pre-latch header context, so an aborting header
            // never leaks into the packet it closes.
            if (do_close) begin
                pkt_src_x <= hdr_src_x;
                pkt_src_y <= hdr_src_y;
                pkt_len   <= cnt;
                pkt_xsum  <= xsum;
                pkt_err   <= close_err;
                if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
            end

            if ((do_orphan || (do_close && (close_err != '0))) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_noc_flit_sink.sv
// Directed bench for noc_flit_sink (X_ID=1, Y_ID=2): flit table plus hold-toggle and reset sequences.
// Latency: outputs sampled on the falling edge after each accepted flit.
// Backpressure: sender holds each flit until receive_ready is seen high.
module tb_noc_flit_sink;
    import noc_flit_sink_pkg::*;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        receive_valid = 1'b0;
    logic        receive_ready;
    logic [31:0] receive_flit = '0;
    logic        receive_is_header = 1'b0;
    logic        receive_is_tail = 1'b0;
    logic        sink_hold = 1'b0;
    logic        pkt_done;
    logic [1:0]  pkt_src_x, pkt_src_y;
    logic [8:0]  pkt_len;
    logic [31:0] pkt_xsum;
    logic [4:0]  pkt_err;
    logic        orphan_flit;
    logic [15:0] pkt_count, err_count;

    int   total = 0;
    int   bad = 0;
    logic last_hold = 1'b0;
    logic exp_rdy;

    noc_flit_sink #(.X_ID(2'd1), .Y_ID(2'd2)) dut (
        .noc_clk           (noc_clk),
        .noc_rst_n         (noc_rst_n),
        .receive_valid     (receive_valid),
        .receive_ready     (receive_ready),
        .receive_flit      (receive_flit),
        .receive_is_header (receive_is_header),
        .receive_is_tail   (receive_is_tail),
        .sink_hold         (sink_hold),
        .pkt_done          (pkt_done),
        .pkt_src_x         (pkt_src_x),
        .pkt_src_y         (pkt_src_y),
        .pkt_len           (pkt_len),
        .pkt_xsum          (pkt_xsum),
        .pkt_err           (pkt_err),
        .orphan_flit       (orphan_flit),
        .pkt_count         (pkt_count),
        .err_count         (err_count)
    );

    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic [31:0] flit;
        logic        hd;
        logic        tl;
        logic        done;
        logic        orphan;
        logic [1:0]  sx;
        logic [1:0]  sy;
        logic [8:0]  len;
        logic [31:0] xsum;
        logic [4:0]  err;
        logic [15:0] pc;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_hdr(input logic [1:0] sx, input logic [1:0] sy,
                                           input logic [1:0] dx, input logic [1:0] dy,
                                           input logic [7:0] len);
        return make_flit(NOC_HEAD_H, sx, sy, dx, dy, len, NOC_HEAD_E);
    endfunction

    function automatic logic [31:0] mk_tail(input logic [1:0] sx, input logic [1:0] sy,
                                            input logic [1:0] dx, input logic [1:0] dy);
        return make_flit(NOC_TAIL_H, sx, sy, dx, dy, 8'd0, NOC_TAIL_E);
    endfunction

    // Row with no packet close expected
    function automatic vec_t fv(input logic [31:0] f, input logic h, input logic t,
                                input logic o, input logic [15:0] pc, input logic [15:0] ec);
        vec_t v;
        v.flit = f; v.hd = h; v.tl = t; v.done = 1'b0; v.orphan = o;
        v.sx = 2'd0; v.sy = 2'd0; v.len = 9'd0; v.xsum = 32'd0; v.err = 5'd0;
        v.pc = pc; v.ec = ec;
        return v;
    endfunction

    // Row whose flit closes a packet
    function automatic vec_t cv(input logic [31:0] f, input logic h, input logic t,
                                input logic [1:0] sx, input logic [1:0] sy, input logic [8:0] len,
                                input logic [31:0] xs, input logic [4:0] err,
                                input logic [15:0] pc, input logic [15:0] ec);
        vec_t v;
        v.flit = f; v.hd = h; v.tl = t; v.done = 1'b1; v.orphan = 1'b0;
        v.sx = sx; v.sy = sy; v.len = len; v.xsum = xs; v.err = err;
        v.pc = pc; v.ec = ec;
        return v;
    endfunction

    // Called at a falling edge; returns at the falling edge after the flit is accepted.
    task automatic send(input logic [31:0] f, input logic h, input logic t);
        int waited;
        waited = 0;
        receive_flit      = f;
        receive_is_header = h;
        receive_is_tail   = t;
        receive_valid     = 1'b1;
        while (!receive_ready && waited < 50) begin
            @(negedge noc_clk);
            waited++;
        end
        if (!receive_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: receive_ready=0 after 50 cycles, expected 1");
            receive_valid = 1'b0;
            return;
        end
        @(negedge noc_clk);
        receive_valid     = 1'b0;
        receive_is_header = 1'b0;
        receive_is_tail   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge noc_clk);
        check("rst_ready", receive_ready, 0);
        check("rst_done", pkt_done, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_err_count", err_count, 0);
        check("rst_xsum", pkt_xsum, 0);
        noc_rst_n = 1'b1;
        check("ready_first_cycle", receive_ready, 0);
        @(negedge noc_clk);
        check("ready_after_release", receive_ready, 1);

        // ---------------- flit table ----------------
        // LEN=0, one all-ones data flit
        vecs.push_back(fv(mk_hdr(2'd0, 2'd0, 2'd1, 2'd2, 8'd0), 1'b1, 1'b0, 1'b0, 16'd0, 16'd0));
        vecs.push_back(fv(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        vecs.push_back(cv(mk_tail(2'd0, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1, 2'd0, 2'd0, 9'd1,
                          32'hFFFF_FFFF, 5'b00000, 16'd1, 16'd0));
        // LEN=3, data 1,2,4,8; tail recognised by markers only
        vecs.push_back(fv(mk_hdr(2'd0, 2'd0, 2'd1, 2'd2, 8'd3), 1'b1, 1'b0, 1'b0, 16'd1, 16'd0));
        vecs.push_back(fv(32'd1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0));
        vecs.push_back(fv(32'd2, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0));
        vecs.push_back(fv(32'd4, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0));
        vecs.push_back(fv(32'd8, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0));
        vecs.push_back(cv(mk_tail(2'd0, 2'd0, 2'd1, 2'd2), 1'b0, 1'b0, 2'd0, 2'd0, 9'd4,
                          32'd15, 5'b00000, 16'd2, 16'd0));
        // LEN=3 but only 2 data flits -> length error
        vecs.push_back(fv(mk_hdr(2'd0, 2'd0, 2'd1, 2'd2, 8'd3), 1'b1, 1'b0, 1'b0, 16'd2, 16'd0));
        vecs.push_back(fv(32'd1, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0));
        vecs.push_back(fv(32'd2, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0));
        vecs.push_back(cv(mk_tail(2'd0, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1, 2'd0, 2'd0, 9'd2,
                          32'd3, 5'b00010, 16'd3, 16'd1));
        // Wrong destination 3,3 -> err[0], still consumed
        vecs.push_back(fv(mk_hdr(2'd0, 2'd1, 2'd3, 2'd3, 8'd0), 1'b1, 1'b0, 1'b0, 16'd3, 16'd1));
        vecs.push_back(fv(32'd5, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1));
        vecs.push_back(cv(mk_tail(2'd0, 2'd1, 2'd3, 2'd3), 1'b0, 1'b1, 2'd0, 2'd1, 9'd1,
                          32'd5, 5'b00001, 16'd4, 16'd2));
        // Aborting header from src 2,0, then a clean second packet
        vecs.push_back(fv(mk_hdr(2'd0, 2'd0, 2'd1, 2'd2, 8'd0), 1'b1, 1'b0, 1'b0, 16'd4, 16'd2));
        vecs.push_back(fv(32'd7, 1'b0, 1'b0, 1'b0, 16'd4, 16'd2));
        vecs.push_back(cv(mk_hdr(2'd2, 2'd0, 2'd1, 2'd2, 8'd1), 1'b1, 1'b0, 2'd0, 2'd0, 9'd1,
                          32'd7, 5'b01000, 16'd5, 16'd3));
        vecs.push_back(fv(32'd9, 1'b0, 1'b0, 1'b0, 16'd5, 16'd3));
        vecs.push_back(fv(32'd6, 1'b0, 1'b0, 1'b0, 16'd5, 16'd3));
        vecs.push_back(cv(mk_tail(2'd2, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1, 2'd2, 2'd0, 9'd2,
                          32'd15, 5'b00000, 16'd6, 16'd3));
        // Data with no header -> orphan
        vecs.push_back(fv(32'h11, 1'b0, 1'b0, 1'b1, 16'd6, 16'd4));
        // Tail route mismatch -> err[2]
        vecs.push_back(fv(mk_hdr(2'd1, 2'd1, 2'd1, 2'd2, 8'd0), 1'b1, 1'b0, 1'b0, 16'd6, 16'd4));
        vecs.push_back(fv(32'd3, 1'b0, 1'b0, 1'b0, 16'd6, 16'd4));
        vecs.push_back(cv(mk_tail(2'd1, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1, 2'd1, 2'd1, 9'd1,
                          32'd3, 5'b00100, 16'd7, 16'd5));
        // Bad header markers -> drain to tail, err[4]
        vecs.push_back(fv(make_flit(4'h7, 2'd3, 2'd0, 2'd1, 2'd2, 8'd0, NOC_HEAD_E),
                          1'b1, 1'b0, 1'b0, 16'd7, 16'd5));
        vecs.push_back(fv(32'd1, 1'b0, 1'b0, 1'b0, 16'd7, 16'd5));
        vecs.push_back(cv(mk_tail(2'd3, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1, 2'd3, 2'd0, 9'd0,
                          32'd0, 5'b10000, 16'd8, 16'd6));
        // Stray tail outside a packet -> orphan
        vecs.push_back(fv(mk_tail(2'd0, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1, 1'b1, 16'd8, 16'd7));

        foreach (vecs[i]) begin
            send(vecs[i].flit, vecs[i].hd, vecs[i].tl);
            check($sformatf("v%0d pkt_done", i), pkt_done, vecs[i].done);
            check($sformatf("v%0d orphan", i), orphan_flit, vecs[i].orphan);
            check($sformatf("v%0d pkt_count", i), pkt_count, vecs[i].pc);
            check($sformatf("v%0d err_count", i), err_count, vecs[i].ec);
            if (vecs[i].done) begin
                check($sformatf("v%0d src_x", i), pkt_src_x, vecs[i].sx);
                check($sformatf("v%0d src_y", i), pkt_src_y, vecs[i].sy);
                check($sformatf("v%0d len", i), pkt_len, vecs[i].len);
                check($sformatf("v%0d xsum", i), pkt_xsum, vecs[i].xsum);
                check($sformatf("v%0d err", i), pkt_err, vecs[i].err);
            end
        end

        // ---------------- sink_hold toggling every cycle ----------------
        last_hold = sink_hold;
        fork
            begin
                for (int k = 0; k < 24; k++) begin
                    @(negedge noc_clk);
                    exp_rdy = !last_hold;
                    check("ready_lag", receive_ready, exp_rdy);
                    sink_hold = !sink_hold;
                    @(posedge noc_clk);
                    last_hold = sink_hold;
                end
                @(negedge noc_clk);
                sink_hold = 1'b0;
            end
            begin
                send(mk_hdr(2'd0, 2'd0, 2'd1, 2'd2, 8'd3), 1'b1, 1'b0);
                send(32'd1, 1'b0, 1'b0);
                send(32'd2, 1'b0, 1'b0);
                send(32'd4, 1'b0, 1'b0);
                send(32'd8, 1'b0, 1'b0);
                send(mk_tail(2'd0, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1);
                check("hold_done", pkt_done, 1);
                check("hold_len", pkt_len, 4);
                check("hold_xsum", pkt_xsum, 15);
                check("hold_err", pkt_err, 0);
                check("hold_pkt_count", pkt_count, 9);
            end
        join
        repeat (2) @(negedge noc_clk);

        // ---------------- reset mid-payload ----------------
        send(mk_hdr(2'd0, 2'd0, 2'd1, 2'd2, 8'd3), 1'b1, 1'b0);
        send(32'd1, 1'b0, 1'b0);
        noc_rst_n = 1'b0;
        #1;
        check("mid_rst_done", pkt_done, 0);
        check("mid_rst_ready", receive_ready, 0);
        check("mid_rst_len", pkt_len, 0);
        check("mid_rst_err", pkt_err, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_err_count", err_count, 0);
        repeat (2) @(negedge noc_clk);
        noc_rst_n = 1'b1;
        send(32'd2, 1'b0, 1'b0);
        check("post_rst_orphan1", orphan_flit, 1);
        check("post_rst_done1", pkt_done, 0);
        check("post_rst_err_count1", err_count, 1);
        send(mk_tail(2'd0, 2'd0, 2'd1, 2'd2), 1'b0, 1'b1);
        check("post_rst_orphan2", orphan_flit, 1);
        check("post_rst_done2", pkt_done, 0);
        check("post_rst_err_count2", err_count, 2);
        check("post_rst_pkt_count", pkt_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_flit_sink.md
# noc_flit_sink

Local-port packet receiver and checker for a NoC node: the consuming end of the header/data/tail flit stream that a node's sender emits into the mesh. It accepts flits over a valid/ready handshake, decodes the header, counts and XOR-folds payload flits, and validates the tail against the header. For each packet it reports a completion pulse with source ID, length, checksum and error flags. Each tile sits on the router's local ejection port.

## Interface
Parameters:
- X_ID, 0, this node's X coordinate (`Noc_ID_X_Width bits)
- Y_ID, 0, this node's Y coordinate (`Noc_ID_Y_Width bits)

Ports:
- noc_clk  in  1  clock
- noc_rst_n  in  1  asynchronous active-low reset
- receive_valid  in  1  flit present
- receive_ready  out  1  sink can accept; registered
- receive_flit  in  `Noc_Data_Width  flit word
- receive_is_header  in  1  sideband header marker
- receive_is_tail  in  1  sideband tail marker
- sink_hold  in  1  back-pressure request; deasserts ready one cycle later
- pkt_done  out  1  one-cycle pulse, packet closed
- pkt_src_x  out  `Noc_ID_X_Width  source X of closed packet
- pkt_src_y  out  `Noc_ID_Y_Width  source Y of closed packet
- pkt_len  out  `Axi_LEN_Bit+1  payload flits counted
- pkt_xsum  out  `Noc_Data_Width  XOR of payload flits
- pkt_err  out  5  error flags of closed packet
- orphan_flit  out  1  pulse, flit accepted outside any packet
- pkt_count  out  16  packets closed, saturating
- err_count  out  16  packets closed with any error, plus orphans; saturating

## Operation
- Transfer happens when receive_valid && receive_ready. Nothing changes without a transfer.
- Header detect: receive_is_header = 1 and both header markers match. The markers are [`Noc_Data_Width-1:`Noc_Point_H] == `Noc_Head_H and [`Axi_Len_Point-1:`Noc_Point_E] == `Noc_Head_E.
- Bad header: receive_is_header = 1 but a marker mismatches.
- Tail detect: receive_is_tail = 1, OR both tail markers (`Noc_Tail_H / `Noc_Tail_E) match. The sideband flag alone is not trusted to be driven.
- Header fields used: src X/Y, dst X/Y, and the LEN field. LEN is the AXI convention, so expected payload = LEN+1.
- States:
  - WAIT_HEAD, reset state:
    - Header → latch src/dst/LEN, clear count/xsum, go PAYLOAD.
    - Bad header → set err[4], go DRAIN.
    - Any other flit → orphan_flit pulse, err_count++.
  - PAYLOAD:
    - Tail → close the packet and go WAIT_HEAD. Set err[1] if count ≠ LEN+1. Set err[2] if the tail's src/dst fields differ from the latched header.
    - Header → close the current packet with err[3] set. Latch the new header in the same cycle and stay in PAYLOAD.
    - Otherwise → count++ (saturate at all-ones), xsum ^= flit.
  - DRAIN: discard flits until a tail, then close the packet with the latched flags and go WAIT_HEAD.
- err[0] is set at header latch if dst ≠ {X_ID,Y_ID}. The packet is still consumed.
- Close actions:
  - Drive pkt_src_x/y, pkt_len, pkt_xsum and pkt_err.
  - Pulse pkt_done.
  - pkt_count++.
  - err_count++ if pkt_err ≠ 0.
- Both counters stop at 16'hFFFF.
- Reset values: every output is 0, including receive_ready. State is WAIT_HEAD.

## Timing
- receive_ready <= ~sink_hold every cycle; the first cycle after reset release it is 0. Flits presented while ready = 0 are held by the sender and not consumed.
- Payload outputs and pkt_done are registered. pkt_done is asserted in the cycle after the tail or aborting header is accepted, and the payload outputs are valid in that same cycle. They hold until the next close.
- Back-to-back flow:
  - A header may be accepted in the cycle immediately after a tail.
  - A 3-flit packet at full rate produces pkt_done 1 cycle after its tail.
  - Sustained throughput is 1 flit/cycle.
- Abort case: pkt_done for the old packet and the start of the new packet occur together. The new header's fields do not leak into the old packet's outputs.
- Reset mid-packet: the partial packet is dropped without pkt_done. Flits before the next header are orphans.
- Orphan and close are mutually exclusive, since one flit arrives per cycle.

## Structure
- Add a destination-field offset macro `Noc_Dest_Point to Noc_parameters.v, next to `Noc_Source_Point and `Axi_Len_Point. Error-bit index defines also live there.
- One sub-module is natural: noc_flit_decode, purely combinational. It outputs hdr_hit, bad_hdr, tail_hit, src_x/y, dst_x/y and len from a flit plus the sideband flags.

## Test plan
Bench uses X_ID=1, Y_ID=2, flits built with the standard header/tail layout.
- Header(src 0,0 → 1,2, LEN=0), data 'hFF..F, tail; sink_hold=0 → pkt_done 1 cycle after tail, pkt_len=1, pkt_xsum=all-ones, pkt_err=0, pkt_count=1.
- LEN=3 header, data 1,2,4,8, tail → pkt_len=4, pkt_xsum=15, err=0. Repeat with only 2 data flits → err=5'b00010.
- Header to dst 3,3, then data, tail → err[0]=1, packet consumed, err_count=1.
- Header, data, second header (src 2,0), data, tail → first close err[3]=1 with src 0,0; second close src 2,0, err=0; pkt_count=2.
- Data flit with no header → orphan_flit pulse, err_count+1, no pkt_done. Toggle sink_hold every cycle during a packet → ready lags hold by 1 cycle, no flit lost or duplicated.
- Assert noc_rst_n low mid-payload → all outputs 0, no pkt_done; remaining data and tail flits raise orphan pulses after release.
